urisc_instr_packer: RTL and testbench

//  Writer side of the URISC instruction format: takes operand fields A, B, C one per

---
 rtl/urisc_instr_packer.sv | 198 +++++++++++++++++++
 tb/tb_urisc_instr_packer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/urisc_instr_packer.sv
// -----------------------------------------------------------------------------
// urisc_instr_packer
//
// Writer side of the URISC instruction format. Operand fields A, B and C arrive
// one per handshake, are packed into a single instruction word
// {C, B, A} (A = [ARG_W-1:0], B = [2*ARG_W-1:ARG_W], C = [3*ARG_W-1:2*ARG_W])
// and the word is written to instruction memory at an auto-incrementing
// address. This is the inverse of the core's field slicing. It sits between
// the program loader and the instruction RAM.
//
// Parameters
//   ARG_W       width of each operand field A/B/C
//   ADDR_W      instruction memory address width
//   START_ADDR  first write address after reset
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         synchronous, active-high reset
//   arg_valid   an operand field is present on arg_data
//   arg_ready   the packer accepts a field this cycle (low while writing)
//   arg_sel     field tag: 0=A, 1=B, 2=C, 3=illegal
//   arg_data    operand field value
//   mem_we      write request, held with address/data until mem_ready
//   mem_ready   memory accepts the write this cycle
//   mem_addr    write address, wraps modulo 2^ADDR_W
//   mem_wdata   packed word {C,B,A}; keeps its value after the write
//   addr_wrap   1-cycle pulse: the write at address 2^ADDR_W-1 was accepted
//   err         1-cycle pulse: field sequence error
//
// Configuration
//   URISC_PACKER_SEQCHK_EN  when defined, the tag of every accepted field must
//                           match the slot being filled (A/B/C = 0/1/2). A
//                           wrong or illegal tag discards the field and the
//                           partial word, pulses err and restarts at slot A
//                           without touching the address. When undefined,
//                           arg_sel is ignored, fields are taken strictly in
//                           order and err stays low.
// -----------------------------------------------------------------------------
module urisc_instr_packer #(
  parameter int ARG_W      = 20,
  parameter int ADDR_W     = 10,
  parameter int START_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arg_valid,
  output logic                 arg_ready,
  input  logic [1:0]           arg_sel,
  input  logic [ARG_W-1:0]     arg_data,
  output logic                 mem_we,
  input  logic                 mem_ready,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [3*ARG_W-1:0]   mem_wdata,
  output logic                 addr_wrap,
  output logic                 err
);

`ifdef URISC_PACKER_SEQCHK_EN
  localparam logic SEQ_CHECK = 1'b1;
`else
  localparam logic SEQ_CHECK = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  typedef enum logic [1:0] {
    S_A,
    S_B,
    S_C,
    S_WR
  } stateT;

  stateT state;
  stateT stateNext;

  logic captureA;
  logic captureB;
  logic captureC;
  logic writeAccept;
  logic seqError;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the values from before the edge, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_A;
    end else begin
      state <= stateNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and handshake decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    stateNext   = state;
    arg_ready   = 1'b0;
    mem_we      = 1'b0;
    captureA    = 1'b0;
    captureB    = 1'b0;
    captureC    = 1'b0;
    writeAccept = 1'b0;
    seqError    = 1'b0;

    case (state)
      S_A: begin
        arg_ready = 1'b1;
        if (arg_valid) begin
          if (SEQ_CHECK && (arg_sel != 2'd0)) begin
            seqError = 1'b1;
          end else begin
            captureA  = 1'b1;
            stateNext = S_B;
          end
        end
      end

      S_B: begin
        arg_ready = 1'b1;
        if (arg_valid) begin
          if (SEQ_CHECK && (arg_sel != 2'd1)) begin
            // The partial word is abandoned; slot A is refilled before any
            // write, so the stale slice never reaches memory.
            seqError  = 1'b1;
            stateNext = S_A;
          end else begin
            captureB  = 1'b1;
            stateNext = S_C;
          end
        end
      end

      S_C: begin
        arg_ready = 1'b1;
        if (arg_valid) begin
          if (SEQ_CHECK && (arg_sel != 2'd2)) begin
            seqError  = 1'b1;
            stateNext = S_A;
          end else begin
            captureC  = 1'b1;
            stateNext = S_WR;
          end
        end
      end

      S_WR: begin
        // Request is a pure function of state, so address and data registers
        // are frozen for as long as memory stalls.
        mem_we = 1'b1;
        if (mem_ready) begin
          writeAccept = 1'b1;
          stateNext   = S_A;
        end
      end

      default: begin
        stateNext = S_A;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Word assembly, address counter and status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= FIRST_ADDR;
      mem_wdata <= '0;
      addr_wrap <= 1'b0;
      err       <= 1'b0;
    end else begin
      addr_wrap <= writeAccept && (mem_addr == LAST_ADDR);
      err       <= seqError;

      if (captureA) begin
        mem_wdata[ARG_W-1:0] <= arg_data;
      end
      if (captureB) begin
        mem_wdata[2*ARG_W-1:ARG_W] <= arg_data;
      end
      if (captureC) begin
        mem_wdata[3*ARG_W-1:2*ARG_W] <= arg_data;
      end

      // Natural modulo-2^ADDR_W rollover; the wrap is flagged, not saturated.
      if (writeAccept) begin
        mem_addr <= mem_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_urisc_instr_packer.sv
// -----------------------------------------------------------------------------
// tb_urisc_instr_packer
//
// Self-checking bench for urisc_instr_packer. Two instances share the same
// stimulus: the default configuration (ADDR_W=10) and a small one (ADDR_W=2)
// that wraps every four words. The reference model is the expected word
// {C,B,A} built from the fields fed, and the expected address, which is the
// number of accepted writes since reset modulo 2^ADDR_W.
// -----------------------------------------------------------------------------
module tb_urisc_instr_packer;

  localparam int ARG_W   = 20;
  localparam int ADDR_W  = 10;
  localparam int ADDR_W2 = 2;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int DEPTH2  = 1 << ADDR_W2;

  logic                clk = 1'b0;
  logic                rst;
  logic                arg_valid;
  logic [1:0]          arg_sel;
  logic [ARG_W-1:0]    arg_data;
  logic                mem_ready;

  logic                arg_ready;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [3*ARG_W-1:0]  mem_wdata;
  logic                addr_wrap;
  logic                err;

  logic                arg_ready2;
  logic                mem_we2;
  logic [ADDR_W2-1:0]  mem_addr2;
  logic [3*ARG_W-1:0]  mem_wdata2;
  logic                addr_wrap2;
  logic                err2;

  int compared   = 0;
  int mismatched = 0;
  int expAddr    = 0;
  int expAddr2   = 0;
  int wrapCount  = 0;
  int wrapCount2 = 0;

  always #5 clk = ~clk;

  urisc_instr_packer #(.ARG_W(ARG_W), .ADDR_W(ADDR_W), .START_ADDR(0)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .arg_valid (arg_valid),
    .arg_ready (arg_ready),
    .arg_sel   (arg_sel),
    .arg_data  (arg_data),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .addr_wrap (addr_wrap),
    .err       (err)
  );

  urisc_instr_packer #(.ARG_W(ARG_W), .ADDR_W(ADDR_W2), .START_ADDR(0)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .arg_valid (arg_valid),
    .arg_ready (arg_ready2),
    .arg_sel   (arg_sel),
    .arg_data  (arg_data),
    .mem_we    (mem_we2),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr2),
    .mem_wdata (mem_wdata2),
    .addr_wrap (addr_wrap2),
    .err       (err2)
  );

  // Present one field (after `gap` idle cycles) and check the cycle after.
  task automatic feed(input int gap, input logic [1:0] tag,
                      input logic [ARG_W-1:0] data, input logic expErr);
    for (int i = 0; i < gap; i++) begin
      arg_valid = 1'b0;
      arg_sel   = 2'($urandom);
      arg_data  = ARG_W'($urandom);
      mem_ready = 1'($urandom);
      @(posedge clk); #1;
      compared++;
      if (arg_ready !== 1'b1 || mem_we !== 1'b0 || err !== 1'b0) begin
        mismatched++;
        $display("FAIL idle_field: ready=%b we=%b err=%b, expected 1 0 0",
                 arg_ready, mem_we, err);
      end
    end
    arg_valid = 1'b1;
    arg_sel   = tag;
    arg_data  = data;
    mem_ready = 1'($urandom);
    @(posedge clk); #1;
    arg_valid = 1'b0;
    compared++;
    if (err !== expErr || err2 !== expErr) begin
      mismatched++;
      $display("FAIL err_flag: err=%b err2=%b, expected %b", err, err2, expErr);
    end
    compared++;
    if (addr_wrap !== 1'b0 || addr_wrap2 !== 1'b0) begin
      mismatched++;
      $display("FAIL wrap_idle: wrap=%b wrap2=%b, expected 0 0", addr_wrap, addr_wrap2);
    end
    compared++;
    if (mem_addr !== ADDR_W'(expAddr) || mem_addr2 !== ADDR_W2'(expAddr2)) begin
      mismatched++;
      $display("FAIL addr_hold: addr=%0d addr2=%0d, expected %0d %0d",
               mem_addr, mem_addr2, expAddr, expAddr2);
    end
  endtask

  // Called the cycle after C was accepted: check the request, stall, accept.
  task automatic finish_write(input logic [3*ARG_W-1:0] w, input int stall);
    compared++;
    if (mem_we !== 1'b1 || mem_we2 !== 1'b1 || arg_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL write_start: we=%b we2=%b ready=%b, expected 1 1 0",
               mem_we, mem_we2, arg_ready);
    end
    compared++;
    if (mem_addr !== ADDR_W'(expAddr) || mem_addr2 !== ADDR_W2'(expAddr2)) begin
      mismatched++;
      $display("FAIL write_addr: addr=%0d addr2=%0d, expected %0d %0d",
               mem_addr, mem_addr2, expAddr, expAddr2);
    end
    compared++;
    if (mem_wdata !== w || mem_wdata2 !== w) begin
      mismatched++;
      $display("FAIL write_data: data=%h data2=%h, expected %h", mem_wdata, mem_wdata2, w);
    end
    for (int i = 0; i < stall; i++) begin
      mem_ready = 1'b0;
      arg_valid = 1'($urandom);
      arg_sel   = 2'($urandom);
      arg_data  = ARG_W'($urandom);
      @(posedge clk); #1;
      compared++;
      if (mem_we !== 1'b1 || arg_ready !== 1'b0 || mem_addr !== ADDR_W'(expAddr) ||
          mem_wdata !== w || addr_wrap !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_hold: we=%b ready=%b addr=%0d data=%h wrap=%b, expected 1 0 %0d %h 0",
                 mem_we, arg_ready, mem_addr, mem_wdata, addr_wrap, expAddr, w);
      end
    end
    arg_valid = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    compared++;
    if (mem_we !== 1'b0 || arg_ready !== 1'b1 || arg_ready2 !== 1'b1) begin
      mismatched++;
      $display("FAIL write_done: we=%b ready=%b ready2=%b, expected 0 1 1",
               mem_we, arg_ready, arg_ready2);
    end
    compared++;
    if (addr_wrap !== (expAddr == DEPTH - 1) || addr_wrap2 !== (expAddr2 == DEPTH2 - 1)) begin
      mismatched++;
      $display("FAIL wrap_pulse: wrap=%b wrap2=%b, expected %b %b", addr_wrap, addr_wrap2,
               expAddr == DEPTH - 1, expAddr2 == DEPTH2 - 1);
    end
    if (addr_wrap === 1'b1) wrapCount++;
    if (addr_wrap2 === 1'b1) wrapCount2++;
    expAddr  = (expAddr + 1) % DEPTH;
    expAddr2 = (expAddr2 + 1) % DEPTH2;
    compared++;
    if (mem_addr !== ADDR_W'(expAddr) || mem_addr2 !== ADDR_W2'(expAddr2) || mem_wdata !== w) begin
      mismatched++;
      $display("FAIL addr_advance: addr=%0d addr2=%0d data=%h, expected %0d %0d %h",
               mem_addr, mem_addr2, mem_wdata, expAddr, expAddr2, w);
    end
  endtask

  task automatic send_word(input logic [ARG_W-1:0] a, input logic [ARG_W-1:0] b,
                           input logic [ARG_W-1:0] c, input int gap, input int stall);
    feed(gap, 2'd0, a, 1'b0);
    feed(gap, 2'd1, b, 1'b0);
    feed(gap, 2'd2, c, 1'b0);
    finish_write({c, b, a}, stall);
  endtask

  task automatic pulse_reset();
    rst       = 1'b1;
    arg_valid = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    rst      = 1'b0;
    expAddr  = 0;
    expAddr2 = 0;
  endtask

  task automatic check_reset_state(input string tag);
    compared++;
    if (arg_ready !== 1'b1 || mem_we !== 1'b0 || mem_we2 !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_handshake: ready=%b we=%b we2=%b, expected 1 0 0",
               tag, arg_ready, mem_we, mem_we2);
    end
    compared++;
    if (mem_addr !== '0 || mem_addr2 !== '0) begin
      mismatched++;
      $display("FAIL %s_addr: addr=%0d addr2=%0d, expected 0 0", tag, mem_addr, mem_addr2);
    end
    compared++;
    if (mem_wdata !== '0) begin
      mismatched++;
      $display("FAIL %s_data: data=%h, expected 0", tag, mem_wdata);
    end
    compared++;
    if (addr_wrap !== 1'b0 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_pulses: wrap=%b err=%b, expected 0 0", tag, addr_wrap, err);
    end
  endtask

  task automatic test_reset();
    arg_sel  = 2'd0;
    arg_data = '0;
    rst      = 1'b1;
    arg_valid = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pulse_reset();
    check_reset_state("reset");
  endtask

  task automatic test_basic();
    feed(0, 2'd0, 20'h00001, 1'b0);
    feed(0, 2'd1, 20'h00002, 1'b0);
    feed(0, 2'd2, 20'h00003, 1'b0);
    finish_write(60'h000030000200001, 0);
  endtask

  task automatic test_stall();
    send_word(ARG_W'($urandom), ARG_W'($urandom), ARG_W'($urandom), 0, 0);
    send_word(ARG_W'($urandom), ARG_W'($urandom), ARG_W'($urandom), 0, 5);
    send_word(ARG_W'($urandom), ARG_W'($urandom), ARG_W'($urandom), 0, 0);
  endtask

  task automatic test_gapped();
    feed(2, 2'd0, 20'h00001, 1'b0);
    feed(2, 2'd1, 20'h00002, 1'b0);
    feed(2, 2'd2, 20'h00003, 1'b0);
    finish_write(60'h000030000200001, 0);
  endtask

  task automatic test_wrap();
    pulse_reset();
    wrapCount  = 0;
    wrapCount2 = 0;
    for (int i = 0; i < 5; i++) begin
      send_word(ARG_W'($urandom), ARG_W'($urandom), ARG_W'($urandom), 0, 0);
    end
    compared++;
    if (wrapCount2 !== 1 || expAddr2 !== 1) begin
      mismatched++;
      $display("FAIL wrap_small: pulses=%0d next_addr=%0d, expected 1 1", wrapCount2, expAddr2);
    end
    // Walk the default instance through its full address space.
    for (int i = 5; i < DEPTH + 1; i++) begin
      send_word(ARG_W'($urandom), ARG_W'($urandom), ARG_W'($urandom), 0, 0);
    end
    compared++;
    if (wrapCount !== 1 || mem_addr !== ADDR_W'(1)) begin
      mismatched++;
      $display("FAIL wrap_full: pulses=%0d addr=%0d, expected 1 1", wrapCount, mem_addr);
    end
  endtask

  task automatic test_seq_error();
    logic [ARG_W-1:0] a;
    logic [ARG_W-1:0] b;
    logic [ARG_W-1:0] c;
    a = ARG_W'($urandom);
    b = ARG_W'($urandom);
    c = ARG_W'($urandom);
    feed(0, 2'd0, a, 1'b0);
`ifdef URISC_PACKER_SEQCHK_EN
    feed(0, 2'd2, b, 1'b1);
    compared++;
    if (mem_we !== 1'b0 || arg_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL seq_drop: we=%b ready=%b, expected 0 1", mem_we, arg_ready);
    end
    // One idle cycle first: err must already be back low.
    feed(1, 2'd3, c, 1'b1);
    send_word(c, b, a, 0, 0);
`else
    feed(0, 2'd2, b, 1'b0);
    feed(0, 2'd3, c, 1'b0);
    finish_write({c, b, a}, 0);
`endif
  endtask

  task automatic test_reset_mid();
    send_word(ARG_W'($urandom), ARG_W'($urandom), ARG_W'($urandom), 0, 0);
    feed(0, 2'd0, ARG_W'($urandom), 1'b0);
    feed(0, 2'd1, ARG_W'($urandom), 1'b0);
    pulse_reset();
    check_reset_state("rst_midword");
    send_word(ARG_W'($urandom), ARG_W'($urandom), ARG_W'($urandom), 0, 0);
    feed(0, 2'd0, ARG_W'($urandom), 1'b0);
    feed(0, 2'd1, ARG_W'($urandom), 1'b0);
    feed(0, 2'd2, ARG_W'($urandom), 1'b0);
    compared++;
    if (mem_we !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_prewrite: we=%b, expected 1", mem_we);
    end
    pulse_reset();
    check_reset_state("rst_midwrite");
    send_word(ARG_W'($urandom), ARG_W'($urandom), ARG_W'($urandom), 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [ARG_W-1:0] f [3];
      int gap;
      for (int k = 0; k < 3; k++) begin
        f[k] = ARG_W'($urandom);
        gap  = int'($urandom_range(0, 2));
`ifdef URISC_PACKER_SEQCHK_EN
        feed(gap, 2'(k), f[k], 1'b0);
`else
        feed(gap, 2'($urandom), f[k], 1'b0);
`endif
      end
      finish_write({f[2], f[1], f[0]}, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gapped();
    test_seq_error();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
